// File: rtl/result_stream_pkg.sv
// Shared word layout, packet length and state encoding for the result stream.
package result_stream_pkg;

  localparam int unsigned WordWidth  = 32;
  localparam int unsigned FieldWidth = 8;

  // ROOT word field offsets: {8'b0, k, i, j}
  localparam int unsigned RootKLsb = 16;
  localparam int unsigned RootILsb = 8;
  localparam int unsigned RootJLsb = 0;

  // STATUS word layout: {deadlock, 7'b0, iteration_counter, cycle_counter[15:0]}
  localparam int unsigned StatusDeadlockBit = 31;
  localparam int unsigned StatusIterLsb     = 16;
  localparam int unsigned StatusCycleLsb    = 0;
  localparam int unsigned StatusCycleWidth  = 16;
  localparam logic [StatusCycleWidth-1:0] CycleSatLimit = 16'hFFFF;

  typedef enum logic [1:0] {
    StIdle,
    StHeader,
    StStatus,
    StRoots
  } state_e;

  // Header + status + one word per PU.
  function automatic int unsigned packet_len(input int unsigned pu_count);
    return pu_count + 2;
  endfunction

  function automatic logic [WordWidth-1:0] pack_root_word(input logic [FieldWidth-1:0] k,
                                                          input logic [FieldWidth-1:0] i,
                                                          input logic [FieldWidth-1:0] j);
    logic [WordWidth-1:0] w;
    w = '0;
    w[RootKLsb +: FieldWidth] = k;
    w[RootILsb +: FieldWidth] = i;
    w[RootJLsb +: FieldWidth] = j;
    return w;
  endfunction

  // Cycle count saturates when it no longer fits in 16 bits.
  function automatic logic [WordWidth-1:0] pack_status_word(input logic            deadlock,
                                                            input logic [7:0]      iterations,
                                                            input logic [31:0]     cycles);
    logic [WordWidth-1:0] w;
    w = '0;
    w[StatusDeadlockBit] = deadlock;
    w[StatusIterLsb +: FieldWidth] = iterations;
    w[StatusCycleLsb +: StatusCycleWidth] =
        (cycles[31:16] != '0) ? CycleSatLimit : cycles[15:0];
    return w;
  endfunction

endpackage

// File: rtl/result_stream_out.sv
// Snapshots one decoding round's results and streams them out as a framed packet.
module result_stream_out
  import result_stream_pkg::*;
#(
  parameter int unsigned CODE_DISTANCE_X = 5,
  parameter int unsigned CODE_DISTANCE_Z = 5,
  localparam int unsigned MeasRounds  = (CODE_DISTANCE_X > CODE_DISTANCE_Z) ?
                                        CODE_DISTANCE_X : CODE_DISTANCE_Z,
  localparam int unsigned PuCount     = CODE_DISTANCE_X * CODE_DISTANCE_Z * MeasRounds,
  localparam int unsigned PerDimWidth = $clog2(MeasRounds),
  localparam int unsigned AddrWidth   = 3 * PerDimWidth
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           result_valid,
  input  logic [31:0]                    test_case,
  input  logic [31:0]                    cycle_counter,
  input  logic [7:0]                     iteration_counter,
  input  logic                           deadlock,
  input  logic [AddrWidth*PuCount-1:0]   roots,
  output logic [31:0]                    out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_last,
  output logic                           busy,
  output logic                           overrun
);

  localparam int unsigned IdxWidth  = (PuCount > 1) ? $clog2(PuCount) : 1;
  localparam int unsigned BaseWidth = $clog2(AddrWidth * PuCount);
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(PuCount - 1);

  state_e                       state_q, state_d;
  logic [IdxWidth-1:0]          idx_q, idx_d;
  logic [31:0]                  data_q, data_d;
  logic                         last_q, last_d;
  logic                         overrun_q, overrun_d;
  logic                         result_valid_d;
  logic [31:0]                  status_q;
  logic [AddrWidth*PuCount-1:0] roots_q;

  logic                 start, hs, last_hs, accept;
  logic [IdxWidth-1:0]  idx_sel;
  logic [BaseWidth-1:0] root_base;
  logic [AddrWidth-1:0] root_sel;
  logic [7:0]           root_k, root_i, root_j;
  logic [31:0]          root_word;

  assign start     = result_valid & ~result_valid_d;
  assign out_valid = (state_q != StIdle);
  assign busy      = (state_q != StIdle);
  assign hs        = out_valid & out_ready;
  assign last_hs   = hs && (state_q == StRoots) && (idx_q == LastIdx);
  // A start coinciding with the final handshake begins the next packet immediately.
  assign accept    = start && ((state_q == StIdle) || last_hs);
  assign out_data  = data_q;
  assign out_last  = last_q;
  assign overrun   = overrun_q;

  // Index of the root word to load next; clamped so the select never leaves the bank.
  assign idx_sel = ((state_q == StRoots) && (idx_q != LastIdx)) ? idx_q + 1'b1 : '0;

  // Select one PU root from the snapshot bank and widen each coordinate to a byte.
  always_comb begin
    root_base = BaseWidth'(idx_sel) * BaseWidth'(AddrWidth);
    root_sel  = roots_q[root_base +: AddrWidth];
    root_k    = '0;
    root_i    = '0;
    root_j    = '0;
    root_k[PerDimWidth-1:0] = root_sel[2*PerDimWidth +: PerDimWidth];
    root_i[PerDimWidth-1:0] = root_sel[PerDimWidth +: PerDimWidth];
    root_j[PerDimWidth-1:0] = root_sel[0 +: PerDimWidth];
    root_word = pack_root_word(root_k, root_i, root_j);
  end

  // Next-state, next output word and sticky overrun.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    data_d    = data_q;
    last_d    = last_q;
    overrun_d = overrun_q | (start & ~accept);
    if (accept) begin
      state_d = StHeader;
      idx_d   = '0;
      data_d  = test_case;
      last_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
        end
        StHeader: begin
          if (hs) begin
            state_d = StStatus;
            data_d  = status_q;
          end
        end
        StStatus: begin
          if (hs) begin
            state_d = StRoots;
            idx_d   = '0;
            data_d  = root_word;
            last_d  = (LastIdx == '0);
          end
        end
        StRoots: begin
          if (hs) begin
            if (idx_q == LastIdx) begin
              state_d = StIdle;
              idx_d   = '0;
              data_d  = '0;
              last_d  = 1'b0;
            end else begin
              idx_d  = idx_q + 1'b1;
              data_d = root_word;
              last_d = ((idx_q + 1'b1) == LastIdx);
            end
          end
        end
      endcase
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      idx_q          <= '0;
      data_q         <= '0;
      last_q         <= 1'b0;
      overrun_q      <= 1'b0;
      result_valid_d <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      data_q         <= data_d;
      last_q         <= last_d;
      overrun_q      <= overrun_d;
      result_valid_d <= result_valid;
    end
  end

  // Snapshot bank, loaded only when a round is accepted.
  always_ff @(posedge clk) begin
    if (accept) begin
      status_q <= pack_status_word(deadlock, iteration_counter, cycle_counter);
      roots_q  <= roots;
    end
  end

endmodule
